// File: rtl/pcie_tx_arbiter.sv
// -----------------------------------------------------------------------------
// pcie_tx_arbiter
//
// Two-source arbiter in front of the PCIe core s_axis_tx port. The PIO engine
// (app_*) and the Ethernet-injected TLP stream (eth_*) compete for a single
// AXI4-Stream output (pcie_tx1_*). Whole packets are granted: once a source
// owns the path it keeps it until its tlast beat handshakes. There is a fixed
// one-cycle IDLE bubble between packets. Ties in IDLE are broken by a 1-bit
// round-robin pointer that flips on every completed packet.
//
// The data path is purely combinational: no beat is buffered, modified or
// reordered.
//
// Ports
//   pcie_clk, pcie_rst           clock, synchronous active-high reset
//   app_tx_req / app_tx_ack      PIO engine request / ownership indication
//   app_tx_t*                    PIO engine TLP stream (slave side)
//   eth_tx_t*                    Ethernet TLP stream (slave side); tvalid
//                                doubles as its request
//   pcie_tx1_t*                  stream to the PCIe core (master side)
//   app_pkt_cnt, eth_pkt_cnt     saturating completed-packet counters
//
// Build option
//   TX_ARB_STATS_EN  defined   : packet counters are implemented
//                    undefined : counter ports tie to 0, no counter flops
// -----------------------------------------------------------------------------
module pcie_tx_arbiter #(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8
) (
    input  logic                    pcie_clk,
    input  logic                    pcie_rst,

    input  logic                    app_tx_req,
    output logic                    app_tx_ack,

    input  logic                    app_tx_tvalid,
    input  logic                    app_tx_tlast,
    input  logic [KEEP_WIDTH-1:0]   app_tx_tkeep,
    input  logic [C_DATA_WIDTH-1:0] app_tx_tdata,
    input  logic [3:0]              app_tx_tuser,
    output logic                    app_tx_tready,

    input  logic                    eth_tx_tvalid,
    input  logic                    eth_tx_tlast,
    input  logic [KEEP_WIDTH-1:0]   eth_tx_tkeep,
    input  logic [C_DATA_WIDTH-1:0] eth_tx_tdata,
    input  logic [3:0]              eth_tx_tuser,
    output logic                    eth_tx_tready,

    output logic                    pcie_tx1_tvalid,
    output logic                    pcie_tx1_tlast,
    output logic [KEEP_WIDTH-1:0]   pcie_tx1_tkeep,
    output logic [C_DATA_WIDTH-1:0] pcie_tx1_tdata,
    output logic [3:0]              pcie_tx1_tuser,
    input  logic                    pcie_tx1_tready,

    output logic [31:0]             app_pkt_cnt,
    output logic [31:0]             eth_pkt_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_APP = 2'd1,
        GNT_ETH = 2'd2
    } state_t;

    state_t state;
    logic   rr_eth;     // 0: tie goes to app, 1: tie goes to eth
    logic   ack_q;
    logic   pkt_done;

    // Output beats are forced to 0 in IDLE, so this can only fire in a grant.
    assign pkt_done   = pcie_tx1_tvalid & pcie_tx1_tready & pcie_tx1_tlast;
    assign app_tx_ack = ack_q;

    // Grant FSM; the ack is registered alongside the state it mirrors.
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            state  <= IDLE;
            rr_eth <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (app_tx_req && (!eth_tx_tvalid || !rr_eth)) begin
                        state <= GNT_APP;
                        ack_q <= 1'b1;
                    end else if (eth_tx_tvalid) begin
                        state <= GNT_ETH;
                        ack_q <= 1'b0;
                    end
                end
                GNT_APP, GNT_ETH: begin
                    // Only the handshaked tlast releases the grant; request
                    // or tvalid dropping mid-packet is ignored.
                    if (pkt_done) begin
                        state  <= IDLE;
                        ack_q  <= 1'b0;
                        rr_eth <= ~rr_eth;
                    end
                end
                default: begin
                    state <= IDLE;
                    ack_q <= 1'b0;
                end
            endcase
        end
    end

    // Combinational pass-through of the granted source.
    always_comb begin
        pcie_tx1_tvalid = 1'b0;
        pcie_tx1_tlast  = 1'b0;
        pcie_tx1_tkeep  = '0;
        pcie_tx1_tdata  = '0;
        pcie_tx1_tuser  = '0;
        app_tx_tready   = 1'b0;
        eth_tx_tready   = 1'b0;
        case (state)
            GNT_APP: begin
                pcie_tx1_tvalid = app_tx_tvalid;
                pcie_tx1_tlast  = app_tx_tlast;
                pcie_tx1_tkeep  = app_tx_tkeep;
                pcie_tx1_tdata  = app_tx_tdata;
                pcie_tx1_tuser  = app_tx_tuser;
                app_tx_tready   = pcie_tx1_tready;
            end
            GNT_ETH: begin
                pcie_tx1_tvalid = eth_tx_tvalid;
                pcie_tx1_tlast  = eth_tx_tlast;
                pcie_tx1_tkeep  = eth_tx_tkeep;
                pcie_tx1_tdata  = eth_tx_tdata;
                pcie_tx1_tuser  = eth_tx_tuser;
                eth_tx_tready   = pcie_tx1_tready;
            end
            default: ;
        endcase
    end

`ifdef TX_ARB_STATS_EN
    logic [31:0] app_cnt;
    logic [31:0] eth_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            app_cnt <= '0;
            eth_cnt <= '0;
        end else if (pkt_done) begin
            if (state == GNT_APP) app_cnt <= sat_inc(app_cnt);
            if (state == GNT_ETH) eth_cnt <= sat_inc(eth_cnt);
        end
    end

    assign app_pkt_cnt = app_cnt;
    assign eth_pkt_cnt = eth_cnt;
`else
    assign app_pkt_cnt = '0;
    assign eth_pkt_cnt = '0;
`endif

endmodule
